// File: rtl/chess_pkg.sv
// Shared chess encodings for the board evaluator: colour and piece codes, material weights,
// and the evaluator FSM state type.
package chess_pkg;

    localparam int BOARD_SQ   = 64;
    localparam int MAX_BOARDS = 256;

    localparam logic signed [7:0] WHITE = 8'sd1;
    localparam logic signed [7:0] BLACK = -8'sd1;
    localparam logic signed [7:0] EMPTY = 8'sd0;

    typedef enum logic [2:0] {
        PC_NONE   = 3'd0,
        PC_PAWN   = 3'd1,
        PC_KNIGHT = 3'd2,
        PC_BISHOP = 3'd3,
        PC_ROOK   = 3'd4,
        PC_QUEEN  = 3'd5,
        PC_KING   = 3'd6
    } piece_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CMP     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Material weight of a piece magnitude; anything outside the known set is worth nothing.
    function automatic logic [3:0] piece_weight(input logic [7:0] mag);
        logic [3:0] w;
        case (mag)
            {5'd0, PC_PAWN}:   w = 4'd1;
            {5'd0, PC_KNIGHT}: w = 4'd3;
            {5'd0, PC_BISHOP}: w = 4'd3;
            {5'd0, PC_ROOK}:   w = 4'd5;
            {5'd0, PC_QUEEN}:  w = 4'd9;
            {5'd0, PC_KING}:   w = 4'd0;
            default:           w = 4'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/board_eval_piece_value.sv
// Combinational signed piece code -> signed material value (positive for white pieces).
module piece_value
    import chess_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic signed [7:0]         code,
    output logic signed [SCORE_W-1:0] value
);

    logic [7:0] mag_s;
    logic [3:0] weight_s;

    // Magnitude and weight; -128 folds to 0x80, which has no weight.
    always_comb begin
        if (code[7]) begin
            mag_s = 8'(-code);
        end else begin
            mag_s = 8'(code);
        end
        weight_s = piece_weight(mag_s);
        if (code[7]) begin
            value = -$signed({{(SCORE_W-4){1'b0}}, weight_s});
        end else begin
            value = $signed({{(SCORE_W-4){1'b0}}, weight_s});
        end
    end

endmodule

// File: rtl/board_eval.sv
// Walks a contiguous array of 64-word boards in SDRAM, scores each one from the mover's side
// and keeps the best (lowest index on ties). CPU control over Avalon-MM slave.
module board_eval
    import chess_pkg::*;
#(
    parameter int MAX_BOARDS_P = MAX_BOARDS,
    parameter int SCORE_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    state_e                    state_q, state_d;
    logic [31:0]               src_q, src_d;
    logic [8:0]                n_q, n_d;
    logic                      colour_neg_q, colour_neg_d;
    logic [5:0]                s_q, s_d;
    logic [7:0]                b_q, b_d;
    logic signed [SCORE_W-1:0] acc_q, acc_d;
    logic [31:0]               best_idx_q, best_idx_d;
    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic [8:0]                n_done_q, n_done_d;
    logic                      slave_waitrequest_q, slave_waitrequest_d;
    logic [31:0]               slave_readdata_q, slave_readdata_d;
    logic                      master_read_q, master_read_d;
    logic [31:0]               master_address_q, master_address_d;

    logic                      start_s;
    logic                      arg_wr_s;
    logic                      rd_acc_s;
    logic                      last_s;
    logic signed [SCORE_W-1:0] value_s;
    logic signed [SCORE_W-1:0] score_s;
    logic                      unused_s;

    piece_value #(.SCORE_W(SCORE_W)) u_piece_value (
        .code  (master_readdata[7:0]),
        .value (value_s)
    );

    // Slave accesses only complete while not stalled, i.e. in IDLE or DONE.
    assign start_s  = slave_write & ~slave_waitrequest_q & (slave_address == 4'd0);
    assign arg_wr_s = slave_write & ~slave_waitrequest_q;
    assign rd_acc_s = slave_read & ~slave_waitrequest_q;
    assign last_s   = ({1'b0, b_q} == (n_q - 9'd1));
    assign score_s  = colour_neg_q ? -acc_q : acc_q;
    assign unused_s = ^master_readdata[31:8];

    assign slave_waitrequest = slave_waitrequest_q;
    assign slave_readdata    = slave_readdata_q;
    assign master_read       = master_read_q;
    assign master_address    = master_address_q;
    assign master_write      = 1'b0;
    assign master_writedata  = 32'd0;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= ST_IDLE;
            src_q               <= 32'd0;
            n_q                 <= 9'd0;
            colour_neg_q        <= 1'b0;
            s_q                 <= 6'd0;
            b_q                 <= 8'd0;
            acc_q               <= '0;
            best_idx_q          <= 32'hFFFF_FFFF;
            best_score_q        <= SCORE_MIN;
            n_done_q            <= 9'd0;
            slave_waitrequest_q <= 1'b0;
            slave_readdata_q    <= 32'd0;
            master_read_q       <= 1'b0;
            master_address_q    <= 32'd0;
        end else begin
            state_q             <= state_d;
            src_q               <= src_d;
            n_q                 <= n_d;
            colour_neg_q        <= colour_neg_d;
            s_q                 <= s_d;
            b_q                 <= b_d;
            acc_q               <= acc_d;
            best_idx_q          <= best_idx_d;
            best_score_q        <= best_score_d;
            n_done_q            <= n_done_d;
            slave_waitrequest_q <= slave_waitrequest_d;
            slave_readdata_q    <= slave_readdata_d;
            master_read_q       <= master_read_d;
            master_address_q    <= master_address_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d = (n_q == 9'd0) ? ST_DONE : ST_RD_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (!master_waitrequest) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (master_readdatavalid) begin
                    state_d = (s_q == 6'd63) ? ST_CMP : ST_RD_REQ;
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_CMP:  state_d = last_s ? ST_DONE : ST_RD_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Argument capture, accumulation, best tracking and registered bus outputs.
    always_comb begin
        src_d        = src_q;
        n_d          = n_q;
        colour_neg_d = colour_neg_q;
        s_d          = s_q;
        b_d          = b_q;
        acc_d        = acc_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        n_done_d     = n_done_q;

        if (arg_wr_s) begin
            case (slave_address)
                4'd1: src_d = slave_writedata;
                4'd2: n_d = (slave_writedata > 32'(MAX_BOARDS_P)) ? 9'(MAX_BOARDS_P)
                                                                   : slave_writedata[8:0];
                4'd3: colour_neg_d = slave_writedata[31];
                default: src_d = src_q;
            endcase
        end else begin
            src_d = src_q;
        end

        if (start_s) begin
            s_d          = 6'd0;
            b_d          = 8'd0;
            acc_d        = '0;
            best_idx_d   = 32'hFFFF_FFFF;
            best_score_d = SCORE_MIN;
            n_done_d     = 9'd0;
        end else begin
            case (state_q)
                ST_RD_WAIT: begin
                    if (master_readdatavalid) begin
                        acc_d = acc_q + value_s;
                        s_d   = s_q + 6'd1;
                    end else begin
                        acc_d = acc_q;
                    end
                end
                ST_CMP: begin
                    if (score_s > best_score_q) begin
                        best_idx_d   = {24'd0, b_q};
                        best_score_d = score_s;
                    end else begin
                        best_idx_d   = best_idx_q;
                    end
                    n_done_d = n_done_q + 9'd1;
                    acc_d    = '0;
                    s_d      = 6'd0;
                    if (!last_s) begin
                        b_d = b_q + 8'd1;
                    end else begin
                        b_d = b_q;
                    end
                end
                default: acc_d = acc_q;
            endcase
        end

        slave_waitrequest_d = (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT) ||
                              (state_d == ST_CMP);
        master_read_d = (state_d == ST_RD_REQ);
        if (master_read_d) begin
            master_address_d = src_q + {18'd0, b_d, s_d};
        end else begin
            master_address_d = master_address_q;
        end

        if (rd_acc_s) begin
            case (slave_address)
                4'd0:    slave_readdata_d = best_idx_q;
                4'd1:    slave_readdata_d = {{(32-SCORE_W){best_score_q[SCORE_W-1]}}, best_score_q};
                4'd2:    slave_readdata_d = {23'd0, n_done_q};
                4'd3:    slave_readdata_d = {31'd0, (state_q != ST_IDLE)};
                default: slave_readdata_d = 32'd0;
            endcase
        end else begin
            slave_readdata_d = slave_readdata_q;
        end
    end

endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: CPU bus tasks, a small SDRAM model with optional stalls,
// and hand-computed expected results for a few board sets.
module tb_board_eval;

    localparam int LIMIT = 20000;

    logic        clk;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    logic [31:0] mem [0:2047];
    int          n_checks;
    int          n_fail;
    logic        stall_en;
    logic        pending;
    logic        stalled;
    logic [31:0] paddr;
    logic [31:0] stall_addr;
    int          dly;

    board_eval dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_sq(input int addr, input logic [7:0] code);
        mem[addr] = {24'hA5A5A5, code};
    endtask

    task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data, output int stalls);
        stalls = 0;
        @(negedge clk);
        slave_address   = addr;
        slave_writedata = data;
        slave_write     = 1'b1;
        while (slave_waitrequest && stalls < LIMIT) begin
            @(negedge clk);
            stalls++;
        end
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
        int c;
        c = 0;
        @(negedge clk);
        slave_address = addr;
        slave_read    = 1'b1;
        while (slave_waitrequest && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        slave_read = 1'b0;
        data       = slave_readdata;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (slave_waitrequest && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_timeout"}, 32'(c >= LIMIT), 32'd0);
    endtask

    task automatic check_results(input string tag, input logic [31:0] e_idx,
                                 input logic [31:0] e_score, input logic [31:0] e_done);
        logic [31:0] d;
        cpu_read(4'd0, d);
        check({tag, "_idx"}, d, e_idx);
        cpu_read(4'd1, d);
        check({tag, "_score"}, d, e_score);
        cpu_read(4'd2, d);
        check({tag, "_ndone"}, d, e_done);
        cpu_read(4'd3, d);
        check({tag, "_busy"}, d, 32'd0);
    endtask

    task automatic set_args(input logic [31:0] src, input logic [31:0] n, input logic [31:0] col);
        int st;
        cpu_write(4'd1, src, st);
        cpu_write(4'd2, n, st);
        cpu_write(4'd3, col, st);
    endtask

    task automatic run_eval(input string tag, input logic [31:0] src, input logic [31:0] n,
                            input logic [31:0] col, input logic [31:0] e_idx,
                            input logic [31:0] e_score, input logic [31:0] e_done);
        int st;
        set_args(src, n, col);
        cpu_write(4'd0, 32'd0, st);
        wait_idle(tag);
        check_results(tag, e_idx, e_score, e_done);
    endtask

    // SDRAM model: one outstanding read, optional random stalls and return delay.
    initial begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = 32'd0;
        pending              = 1'b0;
        stalled              = 1'b0;
        paddr                = 32'd0;
        stall_addr           = 32'd0;
        dly                  = 0;
        forever begin
            @(negedge clk);
            master_readdatavalid = 1'b0;
            master_waitrequest   = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
                stalled = 1'b0;
            end else if (pending) begin
                if (dly == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = mem[paddr[10:0]];
                    pending              = 1'b0;
                end else begin
                    dly--;
                end
            end else if (master_read) begin
                if (stalled) check("addr_stable", master_address, stall_addr);
                if (stall_en && $urandom_range(1, 0) == 1) begin
                    master_waitrequest = 1'b1;
                    stalled            = 1'b1;
                    stall_addr         = master_address;
                end else begin
                    stalled = 1'b0;
                    pending = 1'b1;
                    paddr   = master_address;
                    dly     = stall_en ? int'($urandom_range(5, 0)) : 0;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] d;
        int          st;
        logic [7:0]  back_rank [0:7];

        n_checks        = 0;
        n_fail          = 0;
        stall_en        = 1'b0;
        rst_n           = 1'b0;
        slave_address   = 4'd0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = 32'd0;

        for (int i = 0; i < 2048; i++) mem[i] = {24'hA5A5A5, 8'h00};
        // Start position at 0x100: white on squares 0-15, black on 48-63.
        back_rank[0] = 8'd4; back_rank[1] = 8'd2; back_rank[2] = 8'd3; back_rank[3] = 8'd5;
        back_rank[4] = 8'd6; back_rank[5] = 8'd3; back_rank[6] = 8'd2; back_rank[7] = 8'd4;
        for (int i = 0; i < 8; i++) begin
            set_sq(32'h100 + i, back_rank[i]);
            set_sq(32'h108 + i, 8'd1);
            set_sq(32'h130 + i, 8'hFF);
            set_sq(32'h138 + i, 8'(-back_rank[i]));
        end
        // 0x400: rook / queen (+ an 0x80 dud) / pawn on the last square.
        set_sq(32'h405, 8'd4);
        set_sq(32'h440, 8'h80);
        set_sq(32'h44A, 8'd5);
        set_sq(32'h4BF, 8'd1);
        // 0x600: pawn-rook(black)+dud = -4, knight = 3, bishop + dud = 3.
        set_sq(32'h600, 8'd1);
        set_sq(32'h601, 8'hFC);
        set_sq(32'h602, 8'd7);
        set_sq(32'h654, 8'd2);
        set_sq(32'h69E, 8'd3);
        set_sq(32'h69F, 8'hF9);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_waitreq", {31'd0, slave_waitrequest}, 32'd0);
        check("rst_mread", {31'd0, master_read}, 32'd0);
        check("rst_maddr", master_address, 32'd0);
        check("rst_mwrite", {master_write, master_writedata[30:0]}, 32'd0);
        check_results("rst", 32'hFFFF_FFFF, 32'hFFFF_8000, 32'd0);

        run_eval("startpos", 32'h100, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1);
        run_eval("white3", 32'h400, 32'd3, 32'd1, 32'd1, 32'd9, 32'd3);
        run_eval("black3", 32'h400, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd3);
        run_eval("tie_col0", 32'h600, 32'd3, 32'd0, 32'd1, 32'd3, 32'd3);

        stall_en = 1'b1;
        run_eval("stall3", 32'h400, 32'd3, 32'd1, 32'd1, 32'd9, 32'd3);
        stall_en = 1'b0;

        // Zero boards: straight to DONE then IDLE, never stalling the CPU.
        set_args(32'h400, 32'd0, 32'd1);
        cpu_write(4'd0, 32'd0, st);
        check("n0_wr_stall", 32'(st), 32'd0);
        check("n0_waitreq_a", {31'd0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        check("n0_waitreq_b", {31'd0, slave_waitrequest}, 32'd0);
        check_results("n0", 32'hFFFF_FFFF, 32'hFFFF_8000, 32'd0);

        // Reset partway through the first board.
        set_args(32'h400, 32'd3, 32'd1);
        cpu_write(4'd0, 32'd0, st);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_mread", {31'd0, master_read}, 32'd0);
        check("mid_rst_waitreq", {31'd0, slave_waitrequest}, 32'd0);
        rst_n = 1'b1;
        check_results("mid_rst", 32'hFFFF_FFFF, 32'hFFFF_8000, 32'd0);
        run_eval("after_rst", 32'h400, 32'd3, 32'd1, 32'd1, 32'd9, 32'd3);

        // Start while busy: held 3*129 running cycles minus the one spent retiring the first write.
        set_args(32'h400, 32'd3, 32'd1);
        cpu_write(4'd0, 32'd0, st);
        cpu_write(4'd0, 32'd0, st);
        check("busy_stall_cycles", 32'(st), 32'd386);
        cpu_read(4'd3, d);
        check("restart_busy", d, 32'd1);
        wait_idle("restart");
        check_results("restart", 32'd1, 32'd9, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
